// File: rtl/deca_qsys_debug_jtag_master.sv
// JTAG scan master: turns one IR+DR (or DR-only) command into a bit-banged
// TAP sequence on tck/tms/tdi and returns the tdo bits captured while shifting.
module deca_qsys_debug_jtag_master #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo,
  output logic                busy
);

  localparam int MAX_A   = (IR_WIDTH > DR_WIDTH) ? IR_WIDTH : DR_WIDTH;
  localparam int MAX_CNT = (MAX_A > 6) ? MAX_A : 6;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    INIT, IDLE, IR_ENTER, IR_SHIFT, IR_EXIT, DR_ENTER, DR_SHIFT, DR_EXIT, RESP
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    idx_q;        // index of the next TCK to issue in state_q
  logic [DIV_W-1:0]    div_q;        // clk cycles elapsed in the current half
  logic                half_q;       // 0 = low half, 1 = high half
  logic                start_q;      // next clk edge begins the first TCK of a sequence
  logic                tck_q;
  logic                tms_q;
  logic                tdi_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;
  logic [IR_WIDTH-1:0] rsp_ir_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] ir_sh_q;      // outgoing IR bits, consumed LSB first
  logic [DR_WIDTH-1:0] dr_sh_q;      // outgoing DR bits, consumed LSB first

  logic [CNT_W-1:0]    cur_cnt_d;
  state_t              nxt_state_d;
  state_t              emit_state_d;
  logic [CNT_W-1:0]    emit_idx_d;
  logic                emit_tms_d;
  logic                begin_edge_d;

  // Decide which TCK (state, index, tms) is issued at the next low-half edge
  always_comb begin
    cur_cnt_d   = '0;
    nxt_state_d = state_q;
    case (state_q)
      INIT:     begin cur_cnt_d = CNT_W'(6);        nxt_state_d = IDLE;     end
      IR_ENTER: begin cur_cnt_d = CNT_W'(4);        nxt_state_d = IR_SHIFT; end
      IR_SHIFT: begin cur_cnt_d = CNT_W'(IR_WIDTH); nxt_state_d = IR_EXIT;  end
      IR_EXIT:  begin cur_cnt_d = CNT_W'(2);        nxt_state_d = DR_ENTER; end
      DR_ENTER: begin cur_cnt_d = CNT_W'(3);        nxt_state_d = DR_SHIFT; end
      DR_SHIFT: begin cur_cnt_d = CNT_W'(DR_WIDTH); nxt_state_d = DR_EXIT;  end
      DR_EXIT:  begin cur_cnt_d = CNT_W'(2);        nxt_state_d = RESP;     end
      default:  begin cur_cnt_d = '0;               nxt_state_d = state_q;  end
    endcase

    if (idx_q >= cur_cnt_d) begin
      emit_state_d = nxt_state_d;
      emit_idx_d   = '0;
    end else begin
      emit_state_d = state_q;
      emit_idx_d   = idx_q;
    end

    case (emit_state_d)
      INIT:     emit_tms_d = (emit_idx_d < CNT_W'(5));
      IR_ENTER: emit_tms_d = (emit_idx_d < CNT_W'(2));
      IR_SHIFT: emit_tms_d = (emit_idx_d == CNT_W'(IR_WIDTH - 1));
      IR_EXIT:  emit_tms_d = (emit_idx_d == '0);
      DR_ENTER: emit_tms_d = (emit_idx_d == '0);
      DR_SHIFT: emit_tms_d = (emit_idx_d == CNT_W'(DR_WIDTH - 1));
      DR_EXIT:  emit_tms_d = (emit_idx_d == '0);
      default:  emit_tms_d = tms_q;
    endcase

    begin_edge_d = start_q || (half_q && (div_q == DIV_LAST));
  end

  // Sequencer: command handshake, TCK divider, TAP outputs and tdo capture
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= INIT;
      idx_q       <= '0;
      div_q       <= '0;
      half_q      <= 1'b0;
      start_q     <= 1'b1;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      rsp_ir_q    <= '0;
      rsp_dr_q    <= '0;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= cmd_skip_ir ? DR_ENTER : IR_ENTER;
            idx_q       <= '0;
            start_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            ir_sh_q     <= cmd_ir;
            dr_sh_q     <= cmd_dr;
            rsp_ir_q    <= '0;
            rsp_dr_q    <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          if (begin_edge_d) begin
            // Start of a low half: the only place tms/tdi may change
            start_q <= 1'b0;
            div_q   <= '0;
            half_q  <= 1'b0;
            tck_q   <= 1'b0;
            if (emit_state_d == IDLE) begin
              state_q     <= IDLE;
              idx_q       <= '0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              tdi_q       <= 1'b0;
            end else if (emit_state_d == RESP) begin
              state_q     <= RESP;
              idx_q       <= '0;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              tdi_q       <= 1'b0;
            end else begin
              state_q <= emit_state_d;
              idx_q   <= emit_idx_d + CNT_W'(1);
              tms_q   <= emit_tms_d;
              if (emit_state_d == IR_SHIFT) begin
                tdi_q   <= ir_sh_q[0];
                ir_sh_q <= ir_sh_q >> 1;
              end else if (emit_state_d == DR_SHIFT) begin
                tdi_q   <= dr_sh_q[0];
                dr_sh_q <= dr_sh_q >> 1;
              end else begin
                tdi_q <= 1'b0;
              end
            end
          end else if (div_q == DIV_LAST) begin
            // End of a low half: tck rises and tdo is captured
            div_q  <= '0;
            half_q <= 1'b1;
            tck_q  <= 1'b1;
            if (state_q == IR_SHIFT)
              rsp_ir_q <= (rsp_ir_q >> 1) | (IR_WIDTH'(tdo) << (IR_WIDTH - 1));
            if (state_q == DR_SHIFT)
              rsp_dr_q <= (rsp_dr_q >> 1) | (DR_WIDTH'(tdo) << (DR_WIDTH - 1));
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ir    = rsp_ir_q;
  assign rsp_dr    = rsp_dr_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_deca_qsys_debug_jtag_master.sv
// Testbench for deca_qsys_debug_jtag_master: scenario tasks compare DUT
// behaviour against a TAP-sequence model built from the command.
module tb_deca_qsys_debug_jtag_master;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int DIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0, cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic           cmd_skip_ir = 1'b0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           rsp_valid, rsp_ready = 1'b1;
  logic [IRW-1:0] rsp_ir;
  logic [DRW-1:0] rsp_dr;
  logic           tck, tms, tdi, tdo, busy;

  logic           cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1;
  logic [IRW-1:0] rsp_ir1;
  logic [DRW-1:0] rsp_dr1;
  logic           tck1, tms1, tdi1, busy1;

  int vectors = 0;
  int miscompares = 0;

  // Target model: 0 = tdo is tdi delayed by one TCK, 1 = tied high, 2 = random
  int   tdo_mode = 0;
  logic tdo_q = 1'b0;
  assign tdo = (tdo_mode == 1) ? 1'b1 : tdo_q;

  bit rec_tms[$], rec_tdi[$], rec_tdo[$];
  bit exp_tms[$], exp_tdi[$];

  deca_qsys_debug_jtag_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ir(rsp_ir), .rsp_dr(rsp_dr),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  deca_qsys_debug_jtag_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir),
    .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_ir(rsp_ir1), .rsp_dr(rsp_dr1),
    .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(1'b1), .busy(busy1)
  );

  // Record every TCK as seen by the target, then present the next tdo bit
  always @(posedge tck) begin
    rec_tms.push_back(tms);
    rec_tdi.push_back(tdi);
    rec_tdo.push_back(tdo);
    if (tdo_mode == 0) tdo_q <= tdi;
    else               tdo_q <= 1'($urandom);
  end

  // Expected TAP walk: optional IR scan from Run-Test/Idle, then DR scan
  function automatic void build_exp(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                                    input logic sk);
    exp_tms.delete();
    exp_tdi.delete();
    if (!sk) begin
      exp_tms = {1, 1, 0, 0};
      exp_tdi = {0, 0, 0, 0};
      for (int k = 0; k < IRW; k++) begin
        exp_tms.push_back(k == IRW - 1);
        exp_tdi.push_back(ir[k]);
      end
      exp_tms.push_back(1); exp_tdi.push_back(0);
      exp_tms.push_back(0); exp_tdi.push_back(0);
    end
    exp_tms.push_back(1); exp_tdi.push_back(0);
    exp_tms.push_back(0); exp_tdi.push_back(0);
    exp_tms.push_back(0); exp_tdi.push_back(0);
    for (int k = 0; k < DRW; k++) begin
      exp_tms.push_back(k == DRW - 1);
      exp_tdi.push_back(dr[k]);
    end
    exp_tms.push_back(1); exp_tdi.push_back(0);
    exp_tms.push_back(0); exp_tdi.push_back(0);
  endfunction

  function automatic int diff_q(input bit a[$], input bit b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] != b[i]) d++;
    return d;
  endfunction

  // Drive one command on the default instance and wait for its response
  task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr, input logic sk,
                         output int lat, output logic [IRW-1:0] rir, output logic [DRW-1:0] rdr);
    int w = 0;
    rec_tms.delete(); rec_tdi.delete(); rec_tdo.delete();
    cmd_ir = ir; cmd_dr = dr; cmd_skip_ir = sk; cmd_valid = 1'b1;
    while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = -1;
    rir = rsp_ir;
    rdr = rsp_dr;
  endtask

  task automatic test_reset();
    int k = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001) begin
      miscompares++;
      $display("FAIL reset_outputs: got tck,tms,tdi,rdy,vld,busy=%b expected 010001",
               {tck, tms, tdi, cmd_ready, rsp_valid, busy});
    end
    vectors++;
    if (rsp_ir !== '0 || rsp_dr !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: got ir=%h dr=%h expected 0", rsp_ir, rsp_dr);
    end
    rec_tms.delete(); rec_tdi.delete(); rec_tdo.delete();
    reset_n = 1'b1;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    vectors++;
    if (k != 6 * 2 * DIV + 1) begin
      miscompares++;
      $display("FAIL reset_ready_latency: got %0d expected %0d", k, 6 * 2 * DIV + 1);
    end
    exp_tms = {1, 1, 1, 1, 1, 0};
    vectors++;
    if (diff_q(rec_tms, exp_tms) != 0) begin
      miscompares++;
      $display("FAIL init_tms: got %p expected %p", rec_tms, exp_tms);
    end
    vectors++;
    if (busy !== 1'b0 || tdi !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy_tdi: got busy=%b tdi=%b expected 0 0", busy, tdi);
    end
    $display("reset: ready after %0d cycles, %0d init TCKs", k, rec_tms.size());
  endtask

  task automatic test_loopback();
    logic [IRW-1:0] ir = 2'b10, rir;
    logic [DRW-1:0] dr = 38'h2A_5555_5555, rdr;
    int lat;
    tdo_mode = 0;
    run_cmd(ir, dr, 1'b0, lat, rir, rdr);
    build_exp(ir, dr, 1'b0);
    vectors++;
    if (lat != (11 + IRW + DRW) * 2 * DIV + 1) begin
      miscompares++;
      $display("FAIL loop_latency: got %0d expected %0d", lat, (11 + IRW + DRW) * 2 * DIV + 1);
    end
    vectors++;
    if (rdr !== {dr[DRW-2:0], 1'b0} || rir !== {ir[0], 1'b0}) begin
      miscompares++;
      $display("FAIL loop_rsp: got ir=%h dr=%h expected ir=%h dr=%h", rir, rdr,
               {ir[0], 1'b0}, {dr[DRW-2:0], 1'b0});
    end
    vectors++;
    if (diff_q(rec_tms, exp_tms) != 0 || diff_q(rec_tdi, exp_tdi) != 0) begin
      miscompares++;
      $display("FAIL loop_stream: got %0d tms / %0d tdi differences over %0d TCKs expected 0",
               diff_q(rec_tms, exp_tms), diff_q(rec_tdi, exp_tdi), rec_tms.size());
    end
    $display("loopback: ir=%h dr=%h -> rsp_ir=%h rsp_dr=%h lat=%0d", ir, dr, rir, rdr, lat);
  endtask

  task automatic test_skip_ones();
    logic [IRW-1:0] rir;
    logic [DRW-1:0] dr = DRW'({$urandom(), $urandom()}), rdr;
    int lat;
    tdo_mode = 1;
    run_cmd(2'b11, dr, 1'b1, lat, rir, rdr);
    vectors++;
    if (rec_tms.size() != 5 + DRW) begin
      miscompares++;
      $display("FAIL skip_tck_count: got %0d expected %0d", rec_tms.size(), 5 + DRW);
    end
    vectors++;
    if (rdr !== {DRW{1'b1}} || rir !== '0) begin
      miscompares++;
      $display("FAIL skip_rsp: got ir=%h dr=%h expected ir=0 dr=3fffffffff", rir, rdr);
    end
    vectors++;
    if (lat != (5 + DRW) * 2 * DIV + 1) begin
      miscompares++;
      $display("FAIL skip_latency: got %0d expected %0d", lat, (5 + DRW) * 2 * DIV + 1);
    end
    $display("skip: dr=%h -> rsp_dr=%h lat=%0d", dr, rdr, lat);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [IRW-1:0] ir = IRW'($urandom()), rir, eir;
      logic [DRW-1:0] dr = DRW'({$urandom(), $urandom()}), rdr, edr;
      logic sk = 1'($urandom());
      int lat, doff;
      tdo_mode = 2;
      run_cmd(ir, dr, sk, lat, rir, rdr);
      build_exp(ir, dr, sk);
      doff = sk ? 3 : 9 + IRW;
      eir = '0;
      if (!sk) for (int k = 0; k < IRW; k++) eir[k] = (4 + k < rec_tdo.size()) ? rec_tdo[4 + k] : 1'b0;
      for (int k = 0; k < DRW; k++) edr[k] = (doff + k < rec_tdo.size()) ? rec_tdo[doff + k] : 1'b0;
      vectors++;
      if (diff_q(rec_tms, exp_tms) != 0 || diff_q(rec_tdi, exp_tdi) != 0) begin
        miscompares++;
        $display("FAIL rand_stream[%0d]: got %0d TCKs, %0d tms / %0d tdi differences expected %0d TCKs exact",
                 n, rec_tms.size(), diff_q(rec_tms, exp_tms), diff_q(rec_tdi, exp_tdi), exp_tms.size());
      end
      vectors++;
      if (rir !== eir || rdr !== edr) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: got ir=%h dr=%h expected ir=%h dr=%h", n, rir, rdr, eir, edr);
      end
      vectors++;
      if (lat != exp_tms.size() * 2 * DIV + 1) begin
        miscompares++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, exp_tms.size() * 2 * DIV + 1);
      end
      $display("random[%0d]: skip=%b ir=%h dr=%h -> rsp_ir=%h rsp_dr=%h lat=%0d",
               n, sk, ir, dr, rir, rdr, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [IRW-1:0] rir, ir2 = IRW'($urandom());
    logic [DRW-1:0] rdr, snap, dr2 = DRW'({$urandom(), $urandom()});
    int lat, rdy_seen = 0, unstable = 0;
    tdo_mode = 2;
    rsp_ready = 1'b0;
    run_cmd(IRW'($urandom()), DRW'({$urandom(), $urandom()}), 1'b0, lat, rir, snap);
    cmd_ir = ir2; cmd_dr = dr2; cmd_skip_ir = 1'b1; cmd_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) rdy_seen++;
      if (rsp_valid !== 1'b1 || rsp_dr !== snap) unstable++;
    end
    vectors++;
    if (rdy_seen != 0) begin
      miscompares++;
      $display("FAIL hold_cmd_ready: got ready high on %0d cycles expected 0", rdy_seen);
    end
    vectors++;
    if (unstable != 0) begin
      miscompares++;
      $display("FAIL hold_rsp_stable: got %0d unstable cycles expected 0", unstable);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_handshake: got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, cmd_ready);
    end
    run_cmd(ir2, dr2, 1'b1, lat, rir, rdr);
    vectors++;
    if (lat != (5 + DRW) * 2 * DIV + 1 || rir !== '0) begin
      miscompares++;
      $display("FAIL next_cmd: got lat=%0d ir=%h expected lat=%0d ir=0", lat, rir, (5 + DRW) * 2 * DIV + 1);
    end
    $display("back_to_back: held rsp_dr=%h, next lat=%0d", snap, lat);
  endtask

  task automatic test_reset_mid();
    logic [IRW-1:0] rir, ir = IRW'($urandom());
    logic [DRW-1:0] rdr, dr = DRW'({$urandom(), $urandom()});
    int w = 0, k = 0, lat, vld_seen = 0;
    tdo_mode = 2;
    rec_tms.delete(); rec_tdi.delete(); rec_tdo.delete();
    cmd_ir = ir; cmd_dr = dr; cmd_skip_ir = 1'b1; cmd_valid = 1'b1;
    while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (rec_tms.size() < 3 + 21 && w < 3000) begin @(negedge clk); w++; end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tck, tms, rsp_valid, busy} !== 4'b0101) begin
      miscompares++;
      $display("FAIL midreset_outputs: got tck,tms,vld,busy=%b expected 0101", {tck, tms, rsp_valid, busy});
    end
    rec_tms.delete(); rec_tdi.delete(); rec_tdo.delete();
    reset_n = 1'b1;
    while (!cmd_ready && k < 300) begin
      @(negedge clk); k++;
      if (rsp_valid) vld_seen++;
    end
    exp_tms = {1, 1, 1, 1, 1, 0};
    vectors++;
    if (k != 6 * 2 * DIV + 1 || vld_seen != 0 || diff_q(rec_tms, exp_tms) != 0) begin
      miscompares++;
      $display("FAIL midreset_init: got ready=%0d vld_seen=%0d tms=%p expected ready=%0d vld_seen=0 tms=%p",
               k, vld_seen, rec_tms, 6 * 2 * DIV + 1, exp_tms);
    end
    tdo_mode = 0;
    run_cmd(ir, dr, 1'b0, lat, rir, rdr);
    vectors++;
    if (lat != (11 + IRW + DRW) * 2 * DIV + 1 || rdr !== {dr[DRW-2:0], 1'b0}) begin
      miscompares++;
      $display("FAIL midreset_next: got lat=%0d dr=%h expected lat=%0d dr=%h",
               lat, rdr, (11 + IRW + DRW) * 2 * DIV + 1, {dr[DRW-2:0], 1'b0});
    end
    $display("reset_mid: reinit ready=%0d, next cmd lat=%0d rsp_dr=%h", k, lat, rdr);
  endtask

  task automatic test_clkdiv1();
    int w = 0, lat = 0, still = 0;
    logic prev;
    cmd_ir = 2'b01; cmd_dr = DRW'({$urandom(), $urandom()}); cmd_skip_ir = 1'b0;
    cmd_valid1 = 1'b1;
    while (!cmd_ready1 && w < 300) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid1 = 1'b0;
    prev = tck1;
    while (!rsp_valid1 && lat < 3000) begin
      @(negedge clk); lat++;
      if (lat >= 2 && tck1 === prev) still++;
      prev = tck1;
    end
    vectors++;
    if (lat != (11 + IRW + DRW) * 2 + 1) begin
      miscompares++;
      $display("FAIL div1_latency: got %0d expected %0d", lat, (11 + IRW + DRW) * 2 + 1);
    end
    vectors++;
    if (still != 0) begin
      miscompares++;
      $display("FAIL div1_toggle: got %0d non-toggling cycles expected 0", still);
    end
    vectors++;
    if (rsp_dr1 !== {DRW{1'b1}} || rsp_ir1 !== 2'b11) begin
      miscompares++;
      $display("FAIL div1_rsp: got ir=%h dr=%h expected ir=3 dr=3fffffffff", rsp_ir1, rsp_dr1);
    end
    $display("clkdiv1: lat=%0d rsp_ir=%h rsp_dr=%h", lat, rsp_ir1, rsp_dr1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_loopback();
    test_skip_ones();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
